wb_writer: RTL
==============

# wb_writer

Writeback unit that owns the register file's single write port. It merges ALU results with load data returning from data memory. It keeps an in-order queue of outstanding loads and performs byte/halfword extraction with sign or zero extension. It exports a scoreboard of destination registers with writes still pending, which the decode stage uses to stall. It sits between the MEM stage and the register file, and drives the file's we/wa/wd inputs.

## Interface
- XLEN, 32, datapath width.
- LQ_DEPTH, 2, maximum outstanding loads (power of two, ≥2).

- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result offered this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
- ld_issue_valid  in  1  load issued to memory this cycle.
- ld_issue_rd  in  5  load destination register.
- ld_issue_funct3  in  3  load type (LB/LH/LW/LBU/LHU).
- ld_issue_offset  in  2  address bits [1:0].
- ld_issue_ready  out  1  queue can accept an issue.
- ld_resp_valid  in  1  memory returns load data (oldest first, cannot be stalled).
- ld_resp_data  in  XLEN  aligned 32-bit word containing the loaded data.
- rf_we  out  1  register file write enable.
- rf_wa  out  5  register file write address.
- rf_wd  out  XLEN  register file write data.
- busy_mask  out  32  bit n set means a write to xn is pending.
- err  out  1  sticky protocol-error flag.

## Operation
- Load queue: FIFO of {rd, funct3, offset}.
  - Push on ld_issue_valid && ld_issue_ready.
  - Pop on ld_resp_valid when the queue is non-empty.
  - ld_issue_ready = !full. There is no same-cycle pop bypass.
- Extraction uses the head entry:
  - byte = word[8*offset +: 8]
  - half = word[16*offset[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged and ignores offset.
  - Any other funct3 value is treated as LW and sets err.
- Arbitration: a load response always wins the write port. alu_ready = !ld_resp_valid.
- Write register: each accepted result loads rf_wa/rf_wd at the next edge.
  - rf_we = 1 only if rd != 0.
  - A load to x0 still pops its queue entry.
- busy_mask is the OR of:
  - the rd decode of every valid queue entry;
  - the rf_wa decode while rf_we = 1.
  - Bit 0 is always 0.
  - Multiple loads to the same rd keep the bit set until the last one drains.
- Errors: ld_resp_valid with an empty queue sets err. The response is dropped and nothing is written. err clears only on rst.

## Timing
- Reset values (asynchronous): queue empty, rf_we = 0, rf_wa = 0, rf_wd = 0, busy_mask = 0, err = 0.
  - ld_issue_ready = 1 and alu_ready = !ld_resp_valid during and after reset.
- Latency: result accepted in cycle N → rf_we/rf_wa/rf_wd valid in cycle N+1 → register file updated at the end of N+1.
- Throughput: one write per cycle.
- Issue and response in the same cycle with a non-empty queue: both take effect.
  - Occupancy is unchanged.
  - busy_mask drops the popped entry's rd and adds the new rd (if distinct), then adds the pending-write rd.
- Issue and response in the same cycle with an empty queue: the issue is pushed; the response is an error (the issue is not yet visible).
- Full queue: an issue in the same cycle as a pop is still refused (ld_issue_ready = 0).
- Pointer wrap: LQ_DEPTH-entry circular pointers; full/empty are distinguished by an extra wrap bit.
- rst mid-operation discards all queued loads and any pending write; the next write occurs only after new acceptances.

## Structure
- Shared package riscv_pkg: load funct3 constants (F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101) and the XLEN default.
- Sub-module load_queue: generic synchronous FIFO (parameterised width/depth, async active-high reset, full/empty, peek of head and of all valid entries for the scoreboard).
- Extraction is a pure function inside wb_writer.

## Test plan
- Reset then ALU write:
  - alu_valid = 1, alu_rd = 5, alu_data = 0x1234_5678 in cycle N.
  - Expect rf_we = 1, rf_wa = 5, rf_wd = 0x1234_5678 in N+1; busy_mask[5] = 1 in N+1 only.
- Signed/unsigned extraction with ld_resp_data = 0x80FF_7F01:
  - LB offset 3 → 0xFFFF_FF80.
  - LBU offset 1 → 0x0000_007F.
  - LH offset 2 → 0xFFFF_80FF.
  - LHU offset 0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- Conflict: ALU (rd 3) and a load response (rd 4) in the same cycle.
  - Expect alu_ready = 0 and the load written first.
  - The ALU result is written in the following cycle, with no loss.
- Queue full:
  - Two issues (rd 7, rd 7) → ld_issue_ready = 0 and busy_mask[7] = 1.
  - A third issue plus a response in the same cycle → the issue is refused.
  - After both responses and their writes, busy_mask[7] = 0.
- x0 and error:
  - A load to rd 0 pops with rf_we = 0.
  - A response with an empty queue sets err = 1, writes nothing, and err stays set until rst.
- Async reset:
  - Assert rst mid-cycle with 2 outstanding loads and rf_we = 1.
  - Outputs clear immediately, and the queue is empty afterwards.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: load funct3 encodings, datapath width default and
// the load-queue entry layout used by the writeback unit.
package riscv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } lq_entry_t;

endpackage

// File: rtl/load_queue.sv
// Generic circular FIFO with wrap-bit pointers; exposes the head and every
// slot with its valid flag so the caller can build a scoreboard.
module load_queue #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [WIDTH-1:0]            head,
    output logic [DEPTH-1:0][WIDTH-1:0] entries,
    output logic [DEPTH-1:0]            valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: slots are only observed through the valid flags.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [AW-1:0] rel;
            assign rel         = IDX - rd_ptr_reg[AW-1:0];
            assign entries[gi] = mem[gi];
            assign valid[gi]   = ({1'b0, rel} < count);
        end
    endgenerate

endmodule

// File: rtl/wb_writer.sv
// Writeback unit: arbitrates ALU results and in-order load returns onto the
// register file write port and publishes a pending-write scoreboard.
module wb_writer
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_issue_valid,
    input  logic [4:0]      ld_issue_rd,
    input  logic [2:0]      ld_issue_funct3,
    input  logic [1:0]      ld_issue_offset,
    output logic            ld_issue_ready,
    input  logic            ld_resp_valid,
    input  logic [XLEN-1:0] ld_resp_data,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic [31:0]     busy_mask,
    output logic            err
);

    localparam int QW = $bits(lq_entry_t);

    function automatic logic [XLEN-1:0] extract(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = word[16*off[1] +: 16];
        case (f3)
            F3_LB:   return {{(XLEN-8){b[7]}}, b};
            F3_LBU:  return {{(XLEN-8){1'b0}}, b};
            F3_LH:   return {{(XLEN-16){h[15]}}, h};
            F3_LHU:  return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic f3_known(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    logic                         q_full;
    logic                         q_empty;
    logic [QW-1:0]                q_head;
    logic [LQ_DEPTH-1:0][QW-1:0]  q_entries;
    logic [LQ_DEPTH-1:0]          q_valid;
    lq_entry_t                    head_entry;
    lq_entry_t                    issue_entry;
    lq_entry_t                    slot [LQ_DEPTH];

    assign issue_entry    = '{rd: ld_issue_rd, funct3: ld_issue_funct3, offset: ld_issue_offset};
    assign head_entry     = lq_entry_t'(q_head);
    assign ld_issue_ready = !q_full;
    assign alu_ready      = !ld_resp_valid;

    load_queue #(.WIDTH(QW), .DEPTH(LQ_DEPTH)) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (ld_issue_valid && ld_issue_ready),
        .push_data (issue_entry),
        .pop       (ld_resp_valid && !q_empty),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head),
        .entries   (q_entries),
        .valid     (q_valid)
    );

    generate
        for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_view
            assign slot[gi] = lq_entry_t'(q_entries[gi]);
        end
    endgenerate

    // Load responses cannot be stalled, so they always own the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
            err   <= 1'b0;
        end else if (ld_resp_valid) begin
            if (!q_empty) begin
                rf_we <= (head_entry.rd != 5'd0);
                rf_wa <= head_entry.rd;
                rf_wd <= extract(head_entry.funct3, head_entry.offset, ld_resp_data);
                if (!f3_known(head_entry.funct3)) err <= 1'b1;
            end else begin
                rf_we <= 1'b0;
                err   <= 1'b1;
            end
        end else if (alu_valid) begin
            rf_we <= (alu_rd != 5'd0);
            rf_wa <= alu_rd;
            rf_wd <= alu_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (q_valid[i]) busy_mask[slot[i].rd] = 1'b1;
        end
        if (rf_we) busy_mask[rf_wa] = 1'b1;
        busy_mask[0] = 1'b0;
    end

endmodule
